// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: Moore fetch/execute sequencer that drives the ALU datapath strobes.
// Define ALU_SEQ_MULDIV_EN to enable the MUL (15) / DIV (16) two-result sequence through T6.
module alu_seq_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5,
  parameter int DATA_W   = 32
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Start,
  input  logic                Stall,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowin,
  output logic                ZHighin,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     OP,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  state_t          state;
  logic [OP_W-1:0] opcode;
  logic [3:0]      ra, rb, rc;
  logic [31:0]     opc_num;
  logic            is_alu3, is_muldiv;
  logic            unused_ir;

  assign opcode    = IR[DATA_W-1 -: OP_W];
  assign ra        = IR[DATA_W-OP_W-1 -: 4];
  assign rb        = IR[DATA_W-OP_W-5 -: 4];
  assign rc        = IR[DATA_W-OP_W-9 -: 4];
  assign unused_ir = ^IR[DATA_W-OP_W-13:0];

  // Zero-extend so that opcode 16 still decodes correctly for any OP_W.
  assign opc_num = 32'(opcode);
  assign is_alu3 = (opc_num <= 32'd14);
`ifdef ALU_SEQ_MULDIV_EN
  assign is_muldiv = (opc_num == 32'd15) || (opc_num == 32'd16);
`else
  assign is_muldiv = 1'b0;
`endif

  // Register fields are 4 bits wide; an index beyond the register file selects nothing.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = (32'(idx) < NUM_REGS) ? (NUM_REGS'(1) << idx) : '0;
  endfunction

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (Start) state <= T0;
        T0:      state <= T1;
        T1:      if (!Stall) state <= T2;
        T2:      state <= T3;
        T3:      state <= (is_alu3 || is_muldiv) ? T4 : IDLE;
        T4:      state <= T5;
        T5:      state <= is_muldiv ? T6 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state and the already-loaded IR, so Clear zeroes them at once.
  always_comb begin
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
    {Yin, ZLowin, ZHighin, ZLowout, ZHighout, LOin, HIin}  = '0;
    Rin     = '0;
    Rout    = '0;
    OP      = '0;
    Done    = 1'b0;
    Illegal = 1'b0;
    Busy    = (state != IDLE);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        PCin  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu3) begin
          Rout = reg_sel(rb);
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Rout = reg_sel(ra);
          Yin  = 1'b1;
        end else begin
          Illegal = 1'b1;
        end
      end
      T4: begin
        OP     = opcode;
        ZLowin = 1'b1;
        if (is_muldiv) begin
          Rout    = reg_sel(rb);
          ZHighin = 1'b1;
        end else begin
          Rout = reg_sel(rc);
        end
      end
      T5: begin
        ZLowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin  = reg_sel(ra);
          Done = 1'b1;
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        Done     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 16, number of general registers; legal values 8 or 16.
REQ-002 Parameter OP_W, default 5, width of the opcode field and of OP.
REQ-003 Parameter DATA_W, default 32, width of IR; minimum 20.
REQ-004 Port Clock, input, 1: single clock, rising edge.
REQ-005 Port Clear, input, 1: reset, asynchronous, active-high.
REQ-006 Port Start, input, 1: begin one fetch/execute sequence; sampled only in IDLE.
REQ-007 Port Stall, input, 1: memory not ready; extends T1.
REQ-008 Port IR, input, DATA_W: instruction register contents; fields [DATA_W-1 -: OP_W]=opcode, next 4 bits=Ra, next 4=Rb, next 4=Rc.
REQ-009 Ports PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, LOin, HIin, output, 1 each: datapath strobes.
REQ-010 Ports Rin, Rout, output, NUM_REGS: one-hot register load and drive selects.
REQ-011 Port OP, output, OP_W: ALU operation code.
REQ-012 Ports Busy, Done, Illegal, output, 1: status; Done and Illegal are single-cycle pulses.

Function
REQ-013 The FSM SHALL have states IDLE, T0, T1, T2, T3, T4, T5, T6; all outputs SHALL be decoded from the state register and IR only (Moore).
REQ-014 IDLE: all strobes low, Busy=0; Start=1 at an edge SHALL move to T0; otherwise remain in IDLE.
REQ-015 T0: PCout=MARin=IncPC=1; next T1.
REQ-016 T1: PCin=Read=MDRin=1; Stall=1 SHALL hold T1 with the same strobes; Stall=0 SHALL advance to T2.
REQ-017 T2: MDRout=IRin=1; next T3.
REQ-018 Class decode from opcode: 0-14 ALU3, 15 MUL, 16 DIV, all others illegal.
REQ-019 ALU3: T3 Rout[Rb]=Yin=1; T4 Rout[Rc]=ZLowin=1 with OP=opcode; T5 ZLowout=1, Rin[Ra]=1, Done=1; then IDLE.
REQ-020 MUL/DIV: T3 Rout[Ra]=Yin=1; T4 Rout[Rb]=ZLowin=ZHighin=1 with OP=opcode; T5 ZLowout=LOin=1; T6 ZHighout=HIin=1, Done=1; then IDLE.
REQ-021 Illegal opcode: in T3 no strobes, Illegal=1, Done=0; next IDLE.
REQ-022 OP SHALL equal the opcode in T4 and 0 in every other state.
REQ-023 A register index >= NUM_REGS SHALL assert no Rin/Rout bit; the sequence otherwise proceeds unchanged.
REQ-024 Rin and Rout SHALL each be zero or one-hot in every cycle.
REQ-025 Busy SHALL be 1 in every state except IDLE.
REQ-026 Start while Busy SHALL be ignored; a new sequence requires at least one IDLE cycle.
REQ-027 Latency with Stall=0: Start sampled at edge n -> Done high in cycle n+5 (ALU3) or n+6 (MUL/DIV).

Reset
REQ-028 Clear=1 SHALL force IDLE immediately, regardless of Clock, and drive all outputs to 0.
REQ-029 Clear asserted mid-sequence SHALL abort it with no Done or Illegal pulse; after release, the first edge with Start=1 begins T0.

Configuration
REQ-030 Macro ALU_SEQ_MULDIV_EN defined: opcodes 15 and 16 follow REQ-020, including the T6 state.
REQ-031 Macro ALU_SEQ_MULDIV_EN undefined: opcodes 15 and 16 are illegal per REQ-021; T6, ZHighin, LOin and HIin SHALL be constant 0.

Verification
REQ-032 IR=0x20228000 (opcode 4, Ra=R0, Rb=R4, Rc=R5), Start one cycle -> T3 Rout=0x0010 with Yin; T4 Rout=0x0020 with OP=4 and ZLowin; T5 Rin=0x0001 with ZLowout; Done at start+5.
REQ-033 Same IR with Stall=1 for 3 cycles in T1 -> Read and MDRin held 4 cycles; Done at start+8.
REQ-034 Opcode 15 (Ra=R2, Rb=R3) with macro defined -> T4 ZLowin=ZHighin=1; T5 LOin=1; T6 HIin=1; Done at start+6. Without the macro -> Illegal at start+3, no Rin asserted.
REQ-035 Opcode 31 -> Illegal pulse in T3, Done never asserted, IDLE at start+4.
REQ-036 Clear pulsed mid-cycle during T4 -> all outputs 0 before the next edge, no Done; a following Start completes normally.
REQ-037 NUM_REGS=8 with Ra=9 on an ALU3 opcode -> Rin=0 throughout T5, Done still asserted.
